// File: rtl/cache_ctrl_2wsa_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl_2wsa_if
// Brief    : CPU, main-memory and data-array signals of the 2-way cache ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_ctrl_2wsa_if #(
    parameter int ADDR_W  = 9,
    parameter int INDEX_W = 4
);
    logic [ADDR_W-1:0]  addr_cpu;
    logic               rd_cpu;
    logic               wr_cpu;
    logic               stall_cpu;
    logic               done_cpu;
    logic               hit_cpu;
    logic [ADDR_W-1:0]  addr_mem;
    logic [1:0]         mem_byte;
    logic               rd_mem;
    logic               wr_mem;
    logic               ready_mem;
    logic [INDEX_W-1:0] arr_index;
    logic               arr_way;
    logic               arr_we;
    logic [3:0]         arr_byte_en;
    logic               arr_src;

    // Controller side: serves the CPU, masters memory and data array.
    modport slave (
        input  addr_cpu, rd_cpu, wr_cpu, ready_mem,
        output stall_cpu, done_cpu, hit_cpu, addr_mem, mem_byte, rd_mem, wr_mem,
               arr_index, arr_way, arr_we, arr_byte_en, arr_src
    );

    // Environment side: CPU, memory and data array models.
    modport master (
        output addr_cpu, rd_cpu, wr_cpu, ready_mem,
        input  stall_cpu, done_cpu, hit_cpu, addr_mem, mem_byte, rd_mem, wr_mem,
               arr_index, arr_way, arr_we, arr_byte_en, arr_src
    );
endinterface
`default_nettype wire

// File: rtl/cache_ctrl_2wsa.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl_2wsa
// Brief    : 2-way set-associative cache sequencer: lookup, LRU victim pick,
//            byte-wise write-back and refill over a byte-wide memory port.
// Revision : 1.0 - initial release
// ============================================================================
module cache_ctrl_2wsa #(
    parameter int ADDR_W  = 9,
    parameter int INDEX_W = 4
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    cache_ctrl_2wsa_if.slave   bus
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int SETS  = 1 << INDEX_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COMPARE = 3'd1;
    localparam logic [2:0] S_WB      = 3'd2;
    localparam logic [2:0] S_RF      = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic [2:0]         r_state;
    logic [TAG_W-1:0]   r_tag;
    logic [INDEX_W-1:0] r_index;
    logic               r_wr;
    logic               r_victim;
    logic               r_hit;
    logic               r_first;
    logic [1:0]         r_byte;

    logic [TAG_W-1:0]   r_tags  [SETS][2];
    logic [1:0]         r_valid [SETS];
    logic [1:0]         r_dirty [SETS];
    logic [SETS-1:0]    r_lru;

    logic [1:0] w_valid;
    logic [1:0] w_dirty;
    logic [1:0] w_match;
    logic       w_hit;
    logic       w_hit_way;
    logic       w_victim;
    logic       w_last;
    logic       w_we_cmp;
    logic       w_we_rf;

    assign w_valid    = r_valid[r_index];
    assign w_dirty    = r_dirty[r_index];
    assign w_match[0] = w_valid[0] && (r_tags[r_index][0] == r_tag);
    assign w_match[1] = w_valid[1] && (r_tags[r_index][1] == r_tag);
    assign w_hit      = |w_match;
    assign w_hit_way  = w_match[1];
    // Fill empty ways first so a valid line is only evicted when the set is full.
    assign w_victim   = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : r_lru[r_index]);
    assign w_last     = (r_byte == 2'd3);
    assign w_we_cmp   = (r_state == S_COMPARE) && w_hit && r_wr;
    assign w_we_rf    = (r_state == S_RF) && bus.ready_mem;

    assign bus.stall_cpu   = ((r_state == S_IDLE) && (bus.rd_cpu || bus.wr_cpu)) ||
                             (r_state == S_COMPARE) || (r_state == S_WB) || (r_state == S_RF);
    assign bus.done_cpu    = (r_state == S_DONE);
    assign bus.hit_cpu     = (r_state == S_DONE) && r_hit;
    assign bus.rd_mem      = (r_state == S_RF);
    assign bus.wr_mem      = (r_state == S_WB);
    assign bus.addr_mem    = (r_state == S_WB) ? {r_tags[r_index][r_victim], r_index} :
                             (r_state == S_RF) ? {r_tag, r_index} : '0;
    assign bus.mem_byte    = r_byte;
    assign bus.arr_index   = r_index;
    assign bus.arr_way     = (r_state == S_COMPARE) ? w_hit_way :
                             (r_state == S_RF)      ? r_victim  : 1'b0;
    assign bus.arr_we      = w_we_cmp || w_we_rf;
    assign bus.arr_byte_en = w_we_cmp ? 4'hF : (w_we_rf ? (4'b0001 << r_byte) : 4'h0);
    assign bus.arr_src     = w_we_rf;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_tag    <= '0;
            r_index  <= '0;
            r_wr     <= 1'b0;
            r_victim <= 1'b0;
            r_hit    <= 1'b0;
            r_first  <= 1'b0;
            r_byte   <= 2'd0;
            r_lru    <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s]   <= 2'b00;
                r_dirty[s]   <= 2'b00;
                r_tags[s][0] <= '0;
                r_tags[s][1] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.rd_cpu || bus.wr_cpu) begin
                        r_tag   <= bus.addr_cpu[ADDR_W-1:INDEX_W];
                        r_index <= bus.addr_cpu[INDEX_W-1:0];
                        r_wr    <= !bus.rd_cpu;
                        r_first <= 1'b1;
                        r_state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    r_first <= 1'b0;
                    if (r_first) begin
                        r_hit <= w_hit;
                    end
                    if (w_hit) begin
                        r_lru[r_index] <= ~w_hit_way;
                        if (r_wr) begin
                            r_dirty[r_index][w_hit_way] <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_victim <= w_victim;
                        if (w_valid[w_victim] && w_dirty[w_victim]) begin
                            r_state <= S_WB;
                        end else begin
                            // Line content is about to be overwritten byte by byte.
                            r_valid[r_index][w_victim] <= 1'b0;
                            r_state <= S_RF;
                        end
                    end
                end
                S_WB: begin
                    if (bus.ready_mem) begin
                        r_byte <= r_byte + 2'd1;
                        if (w_last) begin
                            r_dirty[r_index][r_victim] <= 1'b0;
                            r_valid[r_index][r_victim] <= 1'b0;
                            r_state <= S_RF;
                        end
                    end
                end
                S_RF: begin
                    if (bus.ready_mem) begin
                        r_byte <= r_byte + 2'd1;
                        if (w_last) begin
                            r_tags[r_index][r_victim]  <= r_tag;
                            r_valid[r_index][r_victim] <= 1'b1;
                            r_dirty[r_index][r_victim] <= 1'b0;
                            r_state <= S_COMPARE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!bus.rd_cpu && !bus.wr_cpu) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_2wsa.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_ctrl_2wsa
// Brief    : Directed scoreboard bench for the 2-way cache sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl_2wsa;
    typedef struct packed {
        logic       wr;
        logic [8:0] addr;
        logic [1:0] b;
    } xfer_t;

    typedef struct packed {
        logic [3:0] idx;
        logic       way;
        logic [3:0] be;
        logic       src;
    } arrw_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] cyc;
    } done_t;

    logic clock     = 1'b0;
    logic reset_n   = 1'b0;
    logic ready_drv = 1'b1;
    int   cyc       = 0;
    int   hold_cnt  = 0;
    int   hold_used = 0;
    int   n_tests   = 0;
    int   n_fail    = 0;

    xfer_t q_xfer[$];
    arrw_t q_arr[$];
    done_t q_done[$];

    cache_ctrl_2wsa_if #(.ADDR_W(9), .INDEX_W(4)) bus ();

    cache_ctrl_2wsa #(.ADDR_W(9), .INDEX_W(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.ready_mem = ready_drv;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Memory model: stretches one refill byte-2 slot by hold_cnt wait cycles.
    always @(posedge clock) begin
        #1;
        if (hold_used < hold_cnt && bus.rd_mem && bus.mem_byte == 2'd2) begin
            ready_drv = 1'b0;
            hold_used = hold_used + 1;
        end else begin
            ready_drv = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic monitor_loop();
        xfer_t gx, ex;
        arrw_t ga, ea;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (bus.rd_mem || bus.wr_mem)
                    chk("mem_exclusive", 32'(bus.rd_mem && bus.wr_mem), 32'd0);
                if ((bus.rd_mem || bus.wr_mem) && bus.ready_mem) begin
                    gx = '{wr: bus.wr_mem, addr: bus.addr_mem, b: bus.mem_byte};
                    if (q_xfer.size() == 0) chk("xfer_unexpected", 32'(gx), 32'hFFFF_FFFF);
                    else begin
                        ex = q_xfer.pop_front();
                        chk("xfer", 32'(gx), 32'(ex));
                    end
                end
                if (bus.arr_we) begin
                    ga = '{idx: bus.arr_index, way: bus.arr_way, be: bus.arr_byte_en, src: bus.arr_src};
                    if (q_arr.size() == 0) chk("arr_we_unexpected", 32'(ga), 32'hFFFF_FFFF);
                    else begin
                        ea = q_arr.pop_front();
                        chk("arr_write", 32'(ga), 32'(ea));
                    end
                end
                if (bus.done_cpu) begin
                    if (q_done.size() == 0) chk("done_unexpected", 32'(cyc), 32'hFFFF_FFFF);
                    else begin
                        done_t ed;
                        ed = q_done.pop_front();
                        chk("done_cycle", 32'(cyc), ed.cyc);
                        chk("hit_cpu", 32'(bus.hit_cpu), 32'(ed.hit));
                    end
                end
            end
        end
    endtask

    task automatic exp_refill(input logic [8:0] a, input logic way);
        for (int b = 0; b < 4; b++) begin
            q_xfer.push_back('{wr: 1'b0, addr: a, b: 2'(b)});
            q_arr.push_back('{idx: a[3:0], way: way, be: 4'(1 << b), src: 1'b1});
        end
    endtask

    task automatic exp_wb(input logic [8:0] a);
        for (int b = 0; b < 4; b++)
            q_xfer.push_back('{wr: 1'b1, addr: a, b: 2'(b)});
    endtask

    // Called at a falling edge; returns at a falling edge with the FSM back in IDLE.
    task automatic run_req(input logic [8:0] a, input logic wr, input logic hit, input int lat);
        bit seen;
        seen = 1'b0;
        bus.addr_cpu = a;
        bus.rd_cpu   = !wr;
        bus.wr_cpu   = wr;
        q_done.push_back('{hit: hit, cyc: 32'(cyc + 1 + lat)});
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clock);
            if (bus.done_cpu) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        bus.rd_cpu = 1'b0;
        bus.wr_cpu = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_stall"}, 32'(bus.stall_cpu), 32'd0);
        chk({tag, "_done_hit"}, 32'({bus.done_cpu, bus.hit_cpu}), 32'd0);
        chk({tag, "_mem"}, 32'({bus.addr_mem, bus.mem_byte, bus.rd_mem, bus.wr_mem}), 32'd0);
        chk({tag, "_arr"}, 32'({bus.arr_index, bus.arr_way, bus.arr_we, bus.arr_byte_en, bus.arr_src}), 32'd0);
    endtask

    initial begin
        bit seen;
        bus.addr_cpu = '0;
        bus.rd_cpu   = 1'b0;
        bus.wr_cpu   = 1'b0;
        fork
            monitor_loop();
        join_none
        #1;
        chk_outputs_zero("reset");
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        exp_refill(9'h069, 1'b0);
        run_req(9'h069, 1'b0, 1'b0, 6);
        run_req(9'h069, 1'b0, 1'b1, 1);
        q_arr.push_back('{idx: 4'h9, way: 1'b0, be: 4'hF, src: 1'b0});
        run_req(9'h069, 1'b1, 1'b1, 1);
        exp_refill(9'h0E9, 1'b1);
        run_req(9'h0E9, 1'b0, 1'b0, 6);
        exp_wb(9'h069);
        exp_refill(9'h169, 1'b0);
        run_req(9'h169, 1'b0, 1'b0, 10);
        hold_cnt = 3;
        exp_refill(9'h1E9, 1'b1);
        run_req(9'h1E9, 1'b0, 1'b0, 9);
        run_req(9'h169, 1'b0, 1'b1, 1);

        // Abort a refill after byte 1 is presented.
        for (int b = 0; b < 2; b++) begin
            q_xfer.push_back('{wr: 1'b0, addr: 9'h0A3, b: 2'(b)});
            q_arr.push_back('{idx: 4'h3, way: 1'b0, be: 4'(1 << b), src: 1'b1});
        end
        bus.addr_cpu = 9'h0A3;
        bus.rd_cpu   = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clock);
            if (bus.rd_mem && bus.mem_byte == 2'd1) seen = 1'b1;
        end
        if (!seen) chk("rf_byte1_timeout", 32'd0, 32'd1);
        #2;
        bus.rd_cpu = 1'b0;
        reset_n    = 1'b0;
        #1;
        chk_outputs_zero("midop_reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        exp_refill(9'h169, 1'b0);
        run_req(9'h169, 1'b0, 1'b0, 6);

        repeat (3) @(negedge clock);
        chk("xfer_queue_empty", 32'(q_xfer.size()), 32'd0);
        chk("arr_queue_empty", 32'(q_arr.size()), 32'd0);
        chk("done_queue_empty", 32'(q_done.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
